// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: gates the keyed RO, counts its
// prescaled edges over a clk-cycle window and hands the count to the host.
module ro_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int PRE_W       = 4,
    parameter int SETTLE_CYC  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       key,
    input  logic [WIN_W-1:0] window,
    input  logic             ro_out,
    output logic             ro_enable,
    output logic [1:0]       ro_key,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COUNT,
        DONE
    } state_t;

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    state_t state, state_n;

    logic [PRE_W-1:0]       pre;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   rise;
    logic [SET_W-1:0]       set_cnt;
    logic [WIN_W-1:0]       win_q;
    logic [WIN_W-1:0]       win_cnt;

    // RO-domain ripple prescaler; only its MSB crosses into clk
    always_ff @(posedge ro_out or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pre[PRE_W-1]};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) state_n = SETTLE;
            end
            SETTLE: begin
                if (set_cnt == SET_LAST) begin
                    state_n = (win_q == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                if (win_cnt == WIN_W'(1)) state_n = DONE;
            end
            DONE: begin
                if (result_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_cnt <= '0;
            win_cnt <= '0;
        end else begin
            if (state == SETTLE) begin
                set_cnt <= set_cnt + 1'b1;
                win_cnt <= win_q;
            end else begin
                set_cnt <= '0;
                if (state == COUNT) win_cnt <= win_cnt - 1'b1;
            end
        end
    end

    // enable is registered from next state so it never glitches at the RO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_enable <= 1'b0;
            ro_key    <= 2'b00;
            win_q     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            ro_enable <= (state_n == SETTLE) || (state_n == COUNT);
            if (state == IDLE && start) begin
                ro_key   <= key;
                win_q    <= window;
                count    <= '0;
                overflow <= 1'b0;
            end
            if (state == COUNT && rise) begin
                if (&count) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: default instance plus a narrow
// saturating instance, each fed by a gated behavioural ring oscillator.
`timescale 1ns/1ps
module tb_ro_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  key = 2'b00;
    logic [15:0] window = 16'd0;
    logic        ro_out = 1'b0;
    logic        ro_enable;
    logic [1:0]  ro_key;
    logic        busy;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic [15:0] count;
    logic        overflow;

    logic        s_start = 1'b0;
    logic [1:0]  s_key = 2'b00;
    logic [15:0] s_window = 16'd0;
    logic        s_ro = 1'b0;
    logic        s_ro_enable;
    logic [1:0]  s_ro_key;
    logic        s_busy;
    logic        s_valid;
    logic        s_ack = 1'b0;
    logic [3:0]  s_count;
    logic        s_overflow;

    int  errors = 0;
    int  checks = 0;
    real half_ns = 1.0;
    logic free_run = 1'b0;

    always #5 clk = ~clk;

    initial begin
        #0.3;
        forever begin
            #(half_ns);
            if (ro_enable || free_run) ro_out = ~ro_out;
        end
    end

    initial begin
        #0.3;
        forever begin
            #1.0;
            if (s_ro_enable || free_run) s_ro = ~s_ro;
        end
    end

    ro_freq_meter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key),
        .window(window), .ro_out(ro_out), .ro_enable(ro_enable),
        .ro_key(ro_key), .busy(busy), .result_valid(result_valid),
        .result_ack(result_ack), .count(count), .overflow(overflow)
    );

    ro_freq_meter #(.CNT_W(4), .PRE_W(1)) sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .key(s_key),
        .window(s_window), .ro_out(s_ro), .ro_enable(s_ro_enable),
        .ro_key(s_ro_key), .busy(s_busy), .result_valid(s_valid),
        .result_ack(s_ack), .count(s_count), .overflow(s_overflow)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // leaves the bench one negedge after the start cycle, start low again
    task automatic do_start(input logic [1:0] k, input logic [15:0] w);
        @(negedge clk);
        key = k;
        window = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 2; i <= 3000; i++) begin
            @(negedge clk);
            if (result_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst_n = 1'b0;
        free_run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = i[0];
            s_start = i[0];
            key = 2'b11;
            window = 16'd5;
            if ({ro_enable, busy, result_valid, overflow, ro_key, count} !== '0)
                bad++;
            if ({s_ro_enable, s_busy, s_valid, s_overflow, s_ro_key, s_count} !== '0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_outputs: %0d nonzero samples, required 0", bad);
        end
        start = 1'b0;
        s_start = 1'b0;
        free_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ro_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b ro_enable=%b required 0 0",
                     busy, ro_enable);
        end
    endtask

    task automatic test_basic();
        int n;
        int bad;
        logic [15:0] c;
        half_ns = 1.0;
        do_start(2'b10, 16'd320);
        checks++;
        if (ro_enable !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_enable: ro_enable=%b busy=%b required 1 1",
                     ro_enable, busy);
        end
        checks++;
        if (ro_key !== 2'b10) begin
            errors++;
            $display("FAIL basic_key: got %b required 10", ro_key);
        end
        wait_valid(n);
        checks++;
        if (n !== 329) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 329", n);
        end
        checks++;
        if (count < 16'd99 || count > 16'd101) begin
            errors++;
            $display("FAIL basic_count: got %0d required 99..101", count);
        end
        checks++;
        if (overflow !== 1'b0 || ro_enable !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_flags: overflow=%b ro_enable=%b required 0 0",
                     overflow, ro_enable);
        end
        c = count;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (count !== c || result_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL basic_hold: %0d unstable cycles, required 0", bad);
        end
        do_ack();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack: busy=%b valid=%b required 0 0",
                     busy, result_valid);
        end
    endtask

    task automatic test_zero_window();
        int n;
        int bad;
        do_start(2'b01, 16'd0);
        wait_valid(n);
        checks++;
        if (n !== 9 || count !== 16'd0) begin
            errors++;
            $display("FAIL zero_window: latency=%0d count=%0d required 9 0",
                     n, count);
        end
        do_ack();
        do_start(2'b11, 16'd40);
        n = -1;
        bad = 0;
        for (int i = 2; i <= 3000; i++) begin
            @(negedge clk);
            if (ro_key !== 2'b11) bad++;
            if (result_valid) begin
                n = i;
                break;
            end
            start = (i == 4) || (i == 20);
            key = 2'b00;
            window = 16'd5;
        end
        start = 1'b0;
        checks++;
        if (n !== 49 || bad !== 0) begin
            errors++;
            $display("FAIL ignored_start: latency=%0d keybad=%0d required 49 0",
                     n, bad);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || ro_enable !== 1'b0 || ro_key !== 2'b11) begin
            errors++;
            $display("FAIL done_start: valid=%b en=%b key=%b required 1 0 11",
                     result_valid, ro_enable, ro_key);
        end
        @(negedge clk);
        result_ack = 1'b1;
        start = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ro_key !== 2'b11) begin
            errors++;
            $display("FAIL ack_start: busy=%b key=%b required 0 11", busy, ro_key);
        end
    endtask

    task automatic test_saturation();
        int n;
        @(negedge clk);
        s_key = 2'b01;
        s_window = 16'd100;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        n = -1;
        for (int i = 2; i <= 3000; i++) begin
            @(negedge clk);
            if (s_valid) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 109) begin
            errors++;
            $display("FAIL sat_latency: got %0d required 109", n);
        end
        checks++;
        if (s_count !== 4'd15 || s_overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_count: count=%0d ovf=%b required 15 1",
                     s_count, s_overflow);
        end
        @(negedge clk);
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n;
        half_ns = 1.25;
        do_start(2'b10, 16'd320);
        repeat (57) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || count === 16'd0) begin
            errors++;
            $display("FAIL mid_counting: busy=%b count=%0d required 1 nonzero",
                     busy, count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ro_enable !== 1'b0 || count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: en=%b count=%0d busy=%b required 0 0 0",
                     ro_enable, count, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b valid=%b required 0 0",
                     busy, result_valid);
        end
        do_start(2'b01, 16'd320);
        wait_valid(n);
        checks++;
        if (n !== 329 || count < 16'd79 || count > 16'd81) begin
            errors++;
            $display("FAIL post_reset_meas: latency=%0d count=%0d required 329 79..81",
                     n, count);
        end
        do_ack();
    endtask

    task automatic test_key_sweep();
        real halves [4] = '{1.0, 1.25, 1.5, 1.75};
        int  expc [4] = '{312, 250, 208, 178};
        int  n;
        int  keybad;
        int  prev;
        keybad = 0;
        prev = 65536;
        for (int k = 0; k < 4; k++) begin
            half_ns = halves[k];
            do_start(2'(k), 16'd1000);
            n = -1;
            for (int i = 2; i <= 3000; i++) begin
                @(negedge clk);
                if (ro_enable && ro_key !== 2'(k)) keybad++;
                if (result_valid) begin
                    n = i;
                    break;
                end
            end
            checks++;
            if (n !== 1009 || int'(count) < expc[k] - 1 || int'(count) > expc[k] + 1) begin
                errors++;
                $display("FAIL sweep_key%0d: latency=%0d count=%0d required 1009 %0d..%0d",
                         k, n, count, expc[k] - 1, expc[k] + 1);
            end
            checks++;
            if (int'(count) >= prev) begin
                errors++;
                $display("FAIL sweep_order%0d: count=%0d required below %0d",
                         k, count, prev);
            end
            prev = int'(count);
            do_ack();
        end
        checks++;
        if (keybad !== 0) begin
            errors++;
            $display("FAIL sweep_key_stable: %0d changes, required 0", keybad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_window();
        test_saturation();
        test_mid_reset();
        test_key_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
